// File: rtl/qconv_kn2row_tile_seq_pkg.sv
// Shared definitions for the kn2row tile sequencer and its datapath units.
//   - FSM state encoding of the sequencer
//   - phase encoding (which datapath unit a state talks to)
//   - default dimension width and tile LOG2 constants
package qconv_kn2row_tile_seq_pkg;

    localparam int unsigned DIM_W_DEF          = 16;
    localparam int unsigned OC_UNROLL_LOG2_DEF = 3;
    localparam int unsigned TILE_H_LOG2_DEF    = 3;
    localparam int unsigned TILE_W_LOG2_DEF    = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRdIn  = 3'd1,
        StRdK   = 3'd2,
        StMac   = 3'd3,
        StWrOut = 3'd4,
        StFin   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PhInput  = 2'd0,
        PhKernel = 2'd1,
        PhMac    = 2'd2,
        PhWrite  = 2'd3
    } phase_e;

    // Phase served by a handshake state; non-handshake states map to PhInput.
    function automatic phase_e state_phase(state_e st);
        phase_e ph;
        ph = PhInput;
        case (st)
            StRdK:   ph = PhKernel;
            StMac:   ph = PhMac;
            StWrOut: ph = PhWrite;
            default: ph = PhInput;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/qconv_kn2row_tile_seq_if.sv
// Control/handshake bundle between the tile sequencer and the datapath units.
//   master : the sequencer (drives busy/done, phase reqs, tile descriptor)
//   slave  : the controller/datapath side (drives start, cfg, phase acks)
interface qconv_kn2row_tile_seq_if #(
    parameter int unsigned DIM_W          = qconv_kn2row_tile_seq_pkg::DIM_W_DEF,
    parameter int unsigned OC_UNROLL_LOG2 = qconv_kn2row_tile_seq_pkg::OC_UNROLL_LOG2_DEF,
    parameter int unsigned TILE_H_LOG2    = qconv_kn2row_tile_seq_pkg::TILE_H_LOG2_DEF,
    parameter int unsigned TILE_W_LOG2    = qconv_kn2row_tile_seq_pkg::TILE_W_LOG2_DEF
);
    logic                    start;
    logic [DIM_W-1:0]        cfg_out_w;
    logic [DIM_W-1:0]        cfg_out_h;
    logic [DIM_W-1:0]        cfg_out_c;
    logic                    busy;
    logic                    done;
    logic                    rd_in_req;
    logic                    rd_in_ack;
    logic                    rd_k_req;
    logic                    rd_k_ack;
    logic                    mac_req;
    logic                    mac_ack;
    logic                    wr_out_req;
    logic                    wr_out_ack;
    logic [DIM_W-1:0]        tile_oc;
    logic [DIM_W-1:0]        tile_oh;
    logic [DIM_W-1:0]        tile_ow;
    logic [OC_UNROLL_LOG2:0] tile_oc_len;
    logic [TILE_H_LOG2:0]    tile_h_len;
    logic [TILE_W_LOG2:0]    tile_w_len;
    logic                    tile_first;
    logic                    tile_last;

    modport master (
        input  start, cfg_out_w, cfg_out_h, cfg_out_c,
        input  rd_in_ack, rd_k_ack, mac_ack, wr_out_ack,
        output busy, done,
        output rd_in_req, rd_k_req, mac_req, wr_out_req,
        output tile_oc, tile_oh, tile_ow, tile_oc_len, tile_h_len, tile_w_len,
        output tile_first, tile_last
    );

    modport slave (
        output start, cfg_out_w, cfg_out_h, cfg_out_c,
        output rd_in_ack, rd_k_ack, mac_ack, wr_out_ack,
        input  busy, done,
        input  rd_in_req, rd_k_req, mac_req, wr_out_req,
        input  tile_oc, tile_oh, tile_ow, tile_oc_len, tile_h_len, tile_w_len,
        input  tile_first, tile_last
    );

endinterface

// File: rtl/qconv_kn2row_tile_seq_axis_cnt.sv
// One tiling axis: holds the tile origin along a dimension and derives the
// tile length and the wrap flag from it.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_clear       : origin back to 0 (layer start)
//   i_step        : advance origin by one tile, or back to 0 on wrap
//   i_dim         : dimension size
//   o_origin      : current tile origin
//   o_len         : min(2**STEP_LOG2, dim - origin)
//   o_wrap        : this is the last tile along the axis
module qconv_kn2row_tile_seq_axis_cnt #(
    parameter int unsigned DIM_W     = 16,
    parameter int unsigned STEP_LOG2 = 3
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_clear,
    input  logic               i_step,
    input  logic [DIM_W-1:0]   i_dim,
    output logic [DIM_W-1:0]   o_origin,
    output logic [STEP_LOG2:0] o_len,
    output logic               o_wrap
);

    localparam logic [DIM_W:0] STEP = {{DIM_W{1'b0}}, 1'b1} << STEP_LOG2;

    logic [DIM_W-1:0] r_origin;
    logic [DIM_W:0]   w_end;
    logic [DIM_W:0]   w_rem;

    // One extra bit so origin + step never overflows near the top of the range.
    assign w_end  = {1'b0, r_origin} + STEP;
    assign o_wrap = (w_end >= {1'b0, i_dim});
    assign w_rem  = {1'b0, i_dim} - {1'b0, r_origin};

    always_comb begin
        o_len = STEP[STEP_LOG2:0];
        if (w_rem < STEP) begin
            o_len = w_rem[STEP_LOG2:0];
        end
    end

    assign o_origin = r_origin;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_origin <= '0;
        end else if (i_clear) begin
            r_origin <= '0;
        end else if (i_step) begin
            r_origin <= o_wrap ? '0 : w_end[DIM_W-1:0];
        end
    end

endmodule

// File: rtl/qconv_kn2row_tile_seq.sv
// Tile sequencer for the kn2row quantised convolution engine.
// Walks output-channel groups (outer), then output rows, then output columns
// (fastest) and runs READ_INPUT -> READ_KERNEL -> CALC_MAC -> WRITE_OUTPUT per
// tile, one req/ack handshake per phase.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   bus (master)  : start/cfg in, busy/done out, four req/ack pairs, tile descriptor
// Build option: QCONV_KERNEL_REUSE_EN skips the kernel load on every tile that is
// not the first spatial tile of its output-channel group.
module qconv_kn2row_tile_seq
    import qconv_kn2row_tile_seq_pkg::*;
#(
    parameter int unsigned DIM_W          = DIM_W_DEF,
    parameter int unsigned OC_UNROLL_LOG2 = OC_UNROLL_LOG2_DEF,
    parameter int unsigned TILE_H_LOG2    = TILE_H_LOG2_DEF,
    parameter int unsigned TILE_W_LOG2    = TILE_W_LOG2_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    qconv_kn2row_tile_seq_if.master bus
);

    state_e           r_state;
    state_e           w_state_d;
    logic [DIM_W-1:0] r_cfg_w;
    logic [DIM_W-1:0] r_cfg_h;
    logic [DIM_W-1:0] r_cfg_c;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_in_req;
    logic             r_rd_k_req;
    logic             r_mac_req;
    logic             r_wr_out_req;

    logic             w_accept;
    logic             w_cfg_zero;
    logic             w_active;
    logic             w_adv;
    logic             w_tile_first;
    logic             w_tile_last;
    logic             w_ow_wrap;
    logic             w_oh_wrap;
    logic             w_oc_wrap;
    logic [DIM_W-1:0] w_ow;
    logic [DIM_W-1:0] w_oh;
    logic [DIM_W-1:0] w_oc;

    assign w_accept   = (r_state == StIdle) && bus.start;
    assign w_cfg_zero = (bus.cfg_out_w == '0) || (bus.cfg_out_h == '0) || (bus.cfg_out_c == '0);
    assign w_active   = (r_state == StRdIn) || (r_state == StRdK) ||
                        (r_state == StMac)  || (r_state == StWrOut);

    // Flags are only meaningful while a layer is in flight; zero otherwise.
    assign w_tile_first = w_active && (w_ow == '0) && (w_oh == '0);
    assign w_tile_last  = w_active && w_ow_wrap && w_oh_wrap && w_oc_wrap;

    // Axis chain: ow steps every tile, oh on ow wrap, oc on oh wrap.
    qconv_kn2row_tile_seq_axis_cnt #(
        .DIM_W     (DIM_W),
        .STEP_LOG2 (TILE_W_LOG2)
    ) u_cnt_ow (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clear  (w_accept),
        .i_step   (w_adv),
        .i_dim    (r_cfg_w),
        .o_origin (w_ow),
        .o_len    (bus.tile_w_len),
        .o_wrap   (w_ow_wrap)
    );

    qconv_kn2row_tile_seq_axis_cnt #(
        .DIM_W     (DIM_W),
        .STEP_LOG2 (TILE_H_LOG2)
    ) u_cnt_oh (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clear  (w_accept),
        .i_step   (w_adv && w_ow_wrap),
        .i_dim    (r_cfg_h),
        .o_origin (w_oh),
        .o_len    (bus.tile_h_len),
        .o_wrap   (w_oh_wrap)
    );

    qconv_kn2row_tile_seq_axis_cnt #(
        .DIM_W     (DIM_W),
        .STEP_LOG2 (OC_UNROLL_LOG2)
    ) u_cnt_oc (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clear  (w_accept),
        .i_step   (w_adv && w_ow_wrap && w_oh_wrap),
        .i_dim    (r_cfg_c),
        .o_origin (w_oc),
        .o_len    (bus.tile_oc_len),
        .o_wrap   (w_oc_wrap)
    );

    // Each req is a registered decode of the state, so in state X the req of X
    // is high and an ack there always meets a raised req.
    always_comb begin
        w_state_d = r_state;
        w_adv     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d = w_cfg_zero ? StFin : StRdIn;
                end
            end
            StRdIn: begin
                if (bus.rd_in_ack) begin
`ifdef QCONV_KERNEL_REUSE_EN
                    // Kernel buffer still holds this oc group after its first tile.
                    w_state_d = w_tile_first ? StRdK : StMac;
`else
                    w_state_d = StRdK;
`endif
                end
            end
            StRdK: begin
                if (bus.rd_k_ack) begin
                    w_state_d = StMac;
                end
            end
            StMac: begin
                if (bus.mac_ack) begin
                    w_state_d = StWrOut;
                end
            end
            StWrOut: begin
                if (bus.wr_out_ack) begin
                    if (w_tile_last) begin
                        w_state_d = StFin;
                    end else begin
                        w_state_d = StRdIn;
                        w_adv     = 1'b1;
                    end
                end
            end
            StFin: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cfg_w      <= '0;
            r_cfg_h      <= '0;
            r_cfg_c      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_in_req  <= 1'b0;
            r_rd_k_req   <= 1'b0;
            r_mac_req    <= 1'b0;
            r_wr_out_req <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cfg_w <= bus.cfg_out_w;
                r_cfg_h <= bus.cfg_out_h;
                r_cfg_c <= bus.cfg_out_c;
            end
            r_busy       <= (w_state_d == StRdIn) || (w_state_d == StRdK) ||
                            (w_state_d == StMac)  || (w_state_d == StWrOut);
            r_done       <= (w_state_d == StFin);
            r_rd_in_req  <= (w_state_d == StRdIn);
            r_rd_k_req   <= (w_state_d == StRdK);
            r_mac_req    <= (w_state_d == StMac);
            r_wr_out_req <= (w_state_d == StWrOut);
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rd_in_req  = r_rd_in_req;
    assign bus.rd_k_req   = r_rd_k_req;
    assign bus.mac_req    = r_mac_req;
    assign bus.wr_out_req = r_wr_out_req;
    assign bus.tile_oc    = w_oc;
    assign bus.tile_oh    = w_oh;
    assign bus.tile_ow    = w_ow;
    assign bus.tile_first = w_tile_first;
    assign bus.tile_last  = w_tile_last;

endmodule

// File: tb/tb_qconv_kn2row_tile_seq.sv
// Self-checking bench for qconv_kn2row_tile_seq. A reference tile list is built
// from nested loops over the layer dimensions and compared with the descriptors
// captured at each write-output handshake.
module tb_qconv_kn2row_tile_seq;

    localparam int unsigned DIM_W = 16;
    localparam int unsigned OCL   = 3;
    localparam int unsigned THL   = 3;
    localparam int unsigned TWL   = 3;
    localparam int OCU = 1 << OCL;
    localparam int TH  = 1 << THL;
    localparam int TW  = 1 << TWL;

    typedef struct packed {
        logic [15:0] oc;
        logic [15:0] oh;
        logic [15:0] ow;
        logic [3:0]  oc_len;
        logic [3:0]  h_len;
        logic [3:0]  w_len;
        logic        first;
        logic        last;
    } tile_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    qconv_kn2row_tile_seq_if #(
        .DIM_W          (DIM_W),
        .OC_UNROLL_LOG2 (OCL),
        .TILE_H_LOG2    (THL),
        .TILE_W_LOG2    (TWL)
    ) bus_if ();

    qconv_kn2row_tile_seq #(
        .DIM_W          (DIM_W),
        .OC_UNROLL_LOG2 (OCL),
        .TILE_H_LOG2    (THL),
        .TILE_W_LOG2    (TWL)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    tile_t exp_q[$];
    tile_t obs_q[$];
    int    exp_rdk;

    int         acc_wait, done_cycle, done_cnt, rdk_pulses, req_cycles, busy_cycles;
    int         drop_err, bubble_err, desc_err, onehot_err, busy_err;
    bit         timed_out, aborted, abort_desc_nz;
    logic [5:0] abort_outs;

    function automatic tile_t sample_desc();
        tile_t t;
        t.oc     = bus_if.tile_oc;
        t.oh     = bus_if.tile_oh;
        t.ow     = bus_if.tile_ow;
        t.oc_len = bus_if.tile_oc_len;
        t.h_len  = bus_if.tile_h_len;
        t.w_len  = bus_if.tile_w_len;
        t.first  = bus_if.tile_first;
        t.last   = bus_if.tile_last;
        return t;
    endfunction

    function automatic logic [5:0] sample_ctrl();
        return {bus_if.rd_in_req, bus_if.rd_k_req, bus_if.mac_req, bus_if.wr_out_req,
                bus_if.busy, bus_if.done};
    endfunction

    task automatic build_expected(input int w, input int h, input int c);
        tile_t t;
        exp_q.delete();
        exp_rdk = 0;
        for (int oc = 0; oc < c; oc += OCU) begin
            for (int oh = 0; oh < h; oh += TH) begin
                for (int ow = 0; ow < w; ow += TW) begin
                    t.oc     = 16'(oc);
                    t.oh     = 16'(oh);
                    t.ow     = 16'(ow);
                    t.oc_len = 4'((c - oc < OCU) ? c - oc : OCU);
                    t.h_len  = 4'((h - oh < TH) ? h - oh : TH);
                    t.w_len  = 4'((w - ow < TW) ? w - ow : TW);
                    t.first  = (oh == 0) && (ow == 0);
                    t.last   = 1'b0;
                    exp_q.push_back(t);
                    if (t.first) exp_rdk++;
                end
            end
        end
        if (exp_q.size() > 0) begin
            t = exp_q.pop_back();
            t.last = 1'b1;
            exp_q.push_back(t);
        end
`ifndef QCONV_KERNEL_REUSE_EN
        exp_rdk = exp_q.size();
`endif
    endtask

    // Number of differing tiles; a length mismatch counts as a large value.
    function automatic int count_mism();
        int m;
        m = 0;
        if (obs_q.size() != exp_q.size()) return 1000 + obs_q.size();
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) m++;
        end
        return m;
    endfunction

    task automatic set_acks(input logic [3:0] a);
        bus_if.rd_in_ack  = a[0];
        bus_if.rd_k_ack   = a[1];
        bus_if.mac_ack    = a[2];
        bus_if.wr_out_ack = a[3];
    endtask

    // Runs one layer acting as the datapath. abort_tile >= 0 pulls reset during the
    // MAC phase of that tile index and returns right after the reset cycle.
    task automatic run_layer(input int w, input int h, input int c, input int max_dly,
                             input bit stray, input int abort_tile);
        logic [3:0] cur_req, prev_req, acks, prev_fire;
        tile_t      cur, hold;
        bit         hold_valid, accepted;
        int         cyc, dly;
        obs_q.delete();
        acc_wait = 0; done_cycle = -1; done_cnt = 0; rdk_pulses = 0; req_cycles = 0;
        busy_cycles = 0; drop_err = 0; bubble_err = 0; desc_err = 0; onehot_err = 0;
        busy_err = 0; timed_out = 0; aborted = 0; abort_desc_nz = 0; abort_outs = '0;
        bus_if.cfg_out_w = 16'(w);
        bus_if.cfg_out_h = 16'(h);
        bus_if.cfg_out_c = 16'(c);
        set_acks(4'b0);
        bus_if.start = 1'b1;
        accepted = 0;
        while (!accepted && acc_wait < 8) begin
            @(posedge clk); #1;
            acc_wait++;
            accepted = bus_if.busy || bus_if.done;
        end
        bus_if.start = 1'b0;
        if (!accepted) begin
            timed_out = 1;
            return;
        end
        prev_req = '0; prev_fire = '0; hold_valid = 0; hold = '0; cyc = 1; dly = 0;
        forever begin
            cur_req = {bus_if.wr_out_req, bus_if.mac_req, bus_if.rd_k_req, bus_if.rd_in_req};
            cur     = sample_desc();
            if (prev_fire[3]) begin
                obs_q.push_back(hold);
                hold_valid = 0;
            end
            if ((cur_req & prev_fire) != 4'b0) drop_err++;
            if (prev_fire != 4'b0 && cur_req == 4'b0 && !bus_if.done) bubble_err++;
            if ($countones(cur_req) > 1) onehot_err++;
            if (cur_req != 4'b0 && !bus_if.busy) busy_err++;
            if (cur_req[1] && !prev_req[1]) rdk_pulses++;
            if (cur_req != 4'b0) req_cycles++;
            if (bus_if.busy) busy_cycles++;
            if (cur_req != 4'b0) begin
                if (hold_valid && cur != hold) desc_err++;
                if (!hold_valid) begin
                    hold       = cur;
                    hold_valid = 1;
                end
            end
            if (bus_if.done) begin
                done_cnt++;
                done_cycle = cyc;
                if (bus_if.busy) busy_err++;
                set_acks(4'b0);
                bus_if.start = 1'b0;
                break;
            end
            if (abort_tile >= 0 && obs_q.size() == abort_tile && cur_req[2]) begin
                rstn = 1'b0;
                set_acks(4'b0);
                bus_if.start = 1'b0;
                @(posedge clk); #1;
                abort_outs    = sample_ctrl();
                abort_desc_nz = (sample_desc() != '0);
                aborted       = 1;
                rstn          = 1'b1;
                break;
            end
            if (cyc > 4000) begin
                timed_out = 1;
                set_acks(4'b0);
                break;
            end
            if (cur_req != prev_req || prev_fire != 4'b0) dly = int'($urandom_range(max_dly, 0));
            acks = '0;
            if (cur_req != 4'b0) begin
                if (dly == 0) acks = cur_req;
                else dly--;
            end
            if (stray) acks = acks | (4'($urandom) & ~cur_req);
            set_acks(acks);
            if (stray) begin
                bus_if.start     = ($urandom_range(3, 0) == 0);
                bus_if.cfg_out_w = 16'($urandom);
                bus_if.cfg_out_h = 16'($urandom);
                bus_if.cfg_out_c = 16'($urandom);
            end
            prev_req  = cur_req;
            prev_fire = cur_req & acks;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus_if.start = 1'b0;
        bus_if.cfg_out_w = '0;
        bus_if.cfg_out_h = '0;
        bus_if.cfg_out_c = '0;
        set_acks(4'b0);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (sample_ctrl() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", sample_ctrl(), 6'b0);
        end
        n_tests++;
        if (sample_desc() !== tile_t'(0)) begin
            n_fail++;
            $display("FAIL reset_desc: got %h expected 0", sample_desc());
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (sample_ctrl() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle_ctrl: got %b expected %b", sample_ctrl(), 6'b0);
        end
    endtask

    task automatic test_single_tile();
        int m;
        build_expected(8, 8, 8);
        run_layer(8, 8, 8, 0, 0, -1);
        m = count_mism();
        n_tests++;
        if (acc_wait !== 1 || timed_out) begin
            n_fail++;
            $display("FAIL single_accept: got wait %0d timeout %0d expected 1 0", acc_wait, timed_out);
        end
        n_tests++;
        if (done_cycle !== 5) begin
            n_fail++;
            $display("FAIL single_done_latency: got %0d expected 5", done_cycle);
        end
        n_tests++;
        if (m !== 0) begin
            n_fail++;
            $display("FAIL single_tiles: got %0d bad (obs %0d) expected 0 bad (exp %0d)",
                     m, obs_q.size(), exp_q.size());
        end
        n_tests++;
        if (rdk_pulses !== 1 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_counts: got rdk %0d done %0d expected 1 1", rdk_pulses, done_cnt);
        end
    endtask

    task automatic test_edge_tiles();
        int m;
        build_expected(20, 9, 10);
        run_layer(20, 9, 10, 0, 0, -1);
        m = count_mism();
        n_tests++;
        if (m !== 0 || obs_q.size() !== 12) begin
            n_fail++;
            $display("FAIL edge_tiles: got %0d bad, %0d tiles expected 0 bad, 12 tiles",
                     m, obs_q.size());
        end
        n_tests++;
        if (rdk_pulses !== exp_rdk) begin
            n_fail++;
            $display("FAIL edge_rdk_pulses: got %0d expected %0d", rdk_pulses, exp_rdk);
        end
        n_tests++;
        if (done_cnt !== 1 || timed_out || bubble_err !== 0 || drop_err !== 0) begin
            n_fail++;
            $display("FAIL edge_handshake: got done %0d to %0d bubble %0d drop %0d expected 1 0 0 0",
                     done_cnt, timed_out, bubble_err, drop_err);
        end
    endtask

    task automatic test_zero_dim();
        int dims[3][3] = '{'{8, 0, 8}, '{0, 5, 3}, '{4, 4, 0}};
        for (int k = 0; k < 3; k++) begin
            run_layer(dims[k][0], dims[k][1], dims[k][2], 0, 0, -1);
            n_tests++;
            if (done_cycle !== 1 || done_cnt !== 1) begin
                n_fail++;
                $display("FAIL zero_dim_done[%0d]: got cycle %0d count %0d expected 1 1",
                         k, done_cycle, done_cnt);
            end
            n_tests++;
            if (req_cycles !== 0 || busy_cycles !== 0 || obs_q.size() !== 0) begin
                n_fail++;
                $display("FAIL zero_dim_quiet[%0d]: got req %0d busy %0d tiles %0d expected 0 0 0",
                         k, req_cycles, busy_cycles, obs_q.size());
            end
        end
    endtask

    task automatic test_random_delays();
        int w, h, c, m;
        for (int k = 0; k < 6; k++) begin
            w = int'($urandom_range(40, 1));
            h = int'($urandom_range(30, 1));
            c = int'($urandom_range(24, 1));
            build_expected(w, h, c);
            run_layer(w, h, c, 7, 1, -1);
            m = count_mism();
            n_tests++;
            if (m !== 0 || done_cnt !== 1 || timed_out) begin
                n_fail++;
                $display("FAIL random_tiles[%0d] w%0d h%0d c%0d: got %0d bad, %0d tiles, done %0d expected 0 bad, %0d tiles, done 1",
                         k, w, h, c, m, obs_q.size(), done_cnt, exp_q.size());
            end
            n_tests++;
            if (drop_err !== 0 || bubble_err !== 0 || desc_err !== 0 || onehot_err !== 0 ||
                busy_err !== 0) begin
                n_fail++;
                $display("FAIL random_protocol[%0d]: got drop %0d bubble %0d desc %0d onehot %0d busy %0d expected all 0",
                         k, drop_err, bubble_err, desc_err, onehot_err, busy_err);
            end
            n_tests++;
            if (rdk_pulses !== exp_rdk) begin
                n_fail++;
                $display("FAIL random_rdk[%0d]: got %0d expected %0d", k, rdk_pulses, exp_rdk);
            end
        end
    endtask

    task automatic test_reset_mid_layer();
        int m, late_done;
        run_layer(20, 9, 10, 3, 0, 3);
        n_tests++;
        if (!aborted || abort_outs !== 6'b0 || abort_desc_nz) begin
            n_fail++;
            $display("FAIL abort_state: got aborted %0d ctrl %b desc_nz %0d expected 1 000000 0",
                     aborted, abort_outs, abort_desc_nz);
        end
        late_done = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus_if.done || bus_if.busy) late_done++;
        end
        n_tests++;
        if (late_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", late_done);
        end
        build_expected(20, 9, 10);
        run_layer(20, 9, 10, 2, 0, -1);
        m = count_mism();
        n_tests++;
        if (m !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL abort_rerun: got %0d bad, %0d tiles, done %0d expected 0 bad, 12 tiles, done 1",
                     m, obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int m;
        build_expected(17, 8, 9);
        run_layer(17, 8, 9, 1, 0, -1);
        // start is raised already in the done cycle; it must wait for IDLE.
        build_expected(9, 16, 8);
        run_layer(9, 16, 8, 1, 0, -1);
        m = count_mism();
        n_tests++;
        if (acc_wait !== 2) begin
            n_fail++;
            $display("FAIL b2b_accept_after_fin: got wait %0d expected 2", acc_wait);
        end
        n_tests++;
        if (m !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b_tiles: got %0d bad, %0d tiles, done %0d expected 0 bad, %0d tiles, done 1",
                     m, obs_q.size(), done_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_edge_tiles();
        test_zero_dim();
        test_random_delays();
        test_reset_mid_layer();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
